dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Shares the single-port, byte-enabled data memory between two requesters: the pipeline M stage (CPU) and a DMA/bridge port.
- Sits between the M-stage pipeline register and the data memory. Drives the memory's address, write data, byte enable and write strobe.
- CPU has priority. A streak counter guarantees the DMA a slot after a bounded number of consecutive CPU grants.
- Stalls the CPU when it loses arbitration. Returns DMA read data through a registered acknowledge.

Parameters:
- MAX_CPU_STREAK, 4: consecutive CPU grants allowed while DMA is waiting; the next cycle goes to DMA.
- STREAK_W, 3: width of the streak counter; must hold MAX_CPU_STREAK.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  M stage has a load or store this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_be  in  4  byte enables for the store.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, already lane-aligned.
- cpu_rdata  out  32  load data; combinational from mem_rd.
- cpu_stall  out  1  freeze M stage and earlier stages this cycle.
- dma_req  in  1  DMA access pending; held until dma_ack.
- dma_we  in  1  DMA write.
- dma_be  in  4  DMA byte enables.
- dma_addr  in  32  DMA byte address.
- dma_wdata  in  32  DMA write data.
- dma_ack  out  1  one-cycle completion pulse.
- dma_rdata  out  32  registered read data, valid while dma_ack=1.
- mem_a  out  32  memory address.
- mem_wd  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_we  out  1  memory write strobe; the memory writes at posedge.
- mem_rd  in  32  memory combinational read data.
- grant_dma  out  1  memory is driven by the DMA this cycle.

Behaviour:
- State machine has two states: IDLE and DMA_ACK. The registered state is the state, a streak counter, and dma_rdata.
- Reset (synchronous, active-high; clock clk):
  - state=IDLE, streak=0, dma_ack=0, dma_rdata=0.
  - While reset is high: mem_we=0, mem_be=0, mem_a=0, mem_wd=0, cpu_stall=0, grant_dma=0.
- IDLE arbitration (combinational):
  - dma_win = dma_req && (!cpu_req || streak==MAX_CPU_STREAK).
  - cpu_win = cpu_req && !dma_win.
- DMA_ACK:
  - dma_ack=1 for exactly this one cycle.
  - dma_req is ignored; the DMA must drop or renew it after observing the ack.
  - cpu_win = cpu_req; the CPU is never stalled in this state.
  - Next state is IDLE.
- CPU grant:
  - mem_a=cpu_addr, mem_wd=cpu_wdata, mem_be=cpu_be.
  - mem_we=cpu_we; the write commits at the same posedge.
  - cpu_rdata=mem_rd in the same cycle, so load latency is 0 extra cycles.
- DMA grant (IDLE only):
  - mem_* driven from dma_*; grant_dma=1.
  - At the posedge: dma_rdata<=mem_rd, state<=DMA_ACK.
  - DMA latency from grant to ack is 1 cycle.
- Stall: cpu_stall = cpu_req && !cpu_win.
- No grant: mem_we=0, mem_be=0, mem_a=0, mem_wd=0. cpu_rdata=mem_rd at all times.
- Streak counter:
  - In IDLE with cpu_win && dma_req: increment, saturating at MAX_CPU_STREAK.
  - On dma_win: clear to 0.
  - In IDLE with !dma_req: clear to 0.
  - In DMA_ACK: hold.
- Boundary cases:
  - Write with be=4'b0000 is passed through with mem_we=1; the memory treats it as a no-op.
  - Simultaneous CPU and DMA requests with streak<MAX: CPU wins.
  - Reset asserted in DMA_ACK: the ack is suppressed and the DMA transaction is dropped. The DMA must re-request.
  - Read data is never reordered; the CPU sees its load in the cycle it is granted.

Optional Feature:
- Macro: DM_ARB_LOG_EN.
- Defined: on every granted write, the block prints one line at posedge in the format "%d@%h: *%h <= %h". Fields are $time, the literal 32'h0 for the PC, {mem_a[31:2],2'b00}, and mem_wd. A DMA write is prefixed "DMA ".
- Undefined: no simulation output; functional behaviour is identical.

Test Plan:
- Reset held 2 cycles with cpu_req=1, dma_req=1 -> mem_we=0, cpu_stall=0, dma_ack=0, grant_dma=0 throughout.
- CPU-only store cpu_addr=0x10, be=1111, wdata=0xDEADBEEF -> same cycle mem_we=1, mem_a=0x10, mem_wd=0xDEADBEEF, cpu_stall=0. A load of 0x10 next cycle -> cpu_rdata=0xDEADBEEF.
- DMA-only read dma_addr=0x10 -> grant_dma=1 in cycle N; dma_ack=1 and dma_rdata=0xDEADBEEF in cycle N+1; dma_ack=0 in N+2.
- cpu_req and dma_req held high continuously, MAX=4 -> CPU granted 4 cycles (no stall), 5th cycle cpu_stall=1 with grant_dma=1, 6th cycle dma_ack=1 with CPU granted. Pattern repeats.
- Reset asserted in the DMA_ACK cycle -> dma_ack=0 and state IDLE after reset releases; the re-issued DMA request is granted normally.
- DMA byte write be=0100, wdata=0x00AB0000 at 0x20 over 0x11223344 -> a subsequent CPU load returns 0x11AB3344.

Source files
------------

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU M stage has priority, DMA gets a guaranteed slot after a bounded CPU streak.
// Optional write trace enabled by defining DM_ARB_LOG_EN.
module dm_arbiter #(
    parameter int MAX_CPU_STREAK = 4,
    parameter int STREAK_W       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [3:0]  dma_be,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    input  logic [31:0] mem_rd,
    output logic        grant_dma
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        DMA_ACK = 1'b1
    } state_t;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

    state_t              state_r;
    logic [STREAK_W-1:0] streak_r;
    logic [31:0]         dma_rdata_r;
    logic                dma_win_s;
    logic                cpu_win_s;
    logic                at_max_s;

    // Arbitration: DMA only competes from IDLE; the ack cycle always belongs to the CPU.
    always_comb begin
        at_max_s  = (streak_r == STREAK_MAX);
        dma_win_s = 1'b0;
        cpu_win_s = 1'b0;
        if (reset) begin
            dma_win_s = 1'b0;
            cpu_win_s = 1'b0;
        end else if (state_r == IDLE) begin
            dma_win_s = dma_req && (!cpu_req || at_max_s);
            cpu_win_s = cpu_req && !dma_win_s;
        end else begin
            dma_win_s = 1'b0;
            cpu_win_s = cpu_req;
        end
    end

    // Memory port mux; an ungranted cycle drives all zeros so no stray write can occur.
    always_comb begin
        mem_a  = 32'h0000_0000;
        mem_wd = 32'h0000_0000;
        mem_be = 4'b0000;
        mem_we = 1'b0;
        if (dma_win_s) begin
            mem_a  = dma_addr;
            mem_wd = dma_wdata;
            mem_be = dma_be;
            mem_we = dma_we;
        end else if (cpu_win_s) begin
            mem_a  = cpu_addr;
            mem_wd = cpu_wdata;
            mem_be = cpu_be;
            mem_we = cpu_we;
        end else begin
            mem_a  = 32'h0000_0000;
            mem_wd = 32'h0000_0000;
            mem_be = 4'b0000;
            mem_we = 1'b0;
        end
    end

    assign cpu_rdata = mem_rd;
    assign cpu_stall = cpu_req && !cpu_win_s && !reset;
    assign grant_dma = dma_win_s;
    // A reset landing on the ack cycle drops the transaction, so the pulse is masked too.
    assign dma_ack   = (state_r == DMA_ACK) && !reset;
    assign dma_rdata = dma_rdata_r;

    // State, fairness streak and captured DMA read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            streak_r    <= {STREAK_W{1'b0}};
            dma_rdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (dma_win_s) begin
                        dma_rdata_r <= mem_rd;
                        state_r     <= DMA_ACK;
                        streak_r    <= {STREAK_W{1'b0}};
                    end else if (cpu_win_s && dma_req) begin
                        if (!at_max_s) begin
                            streak_r <= streak_r + STREAK_W'(1);
                        end else begin
                            streak_r <= streak_r;
                        end
                    end else if (!dma_req) begin
                        streak_r <= {STREAK_W{1'b0}};
                    end else begin
                        streak_r <= streak_r;
                    end
                end
                DMA_ACK: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    streak_r <= {STREAK_W{1'b0}};
                end
            endcase
        end
    end

`ifdef DM_ARB_LOG_EN
    // Write trace; the PC field is not visible here and is printed as zero.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            if (grant_dma) begin
                $display("DMA %d@%h: *%h <= %h", $time, 32'h0, {mem_a[31:2], 2'b00}, mem_wd);
            end else begin
                $display("%d@%h: *%h <= %h", $time, 32'h0, {mem_a[31:2], 2'b00}, mem_wd);
            end
        end
    end
`else
    // Trace disabled: no simulation output.
`endif

endmodule
